// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches to imem over a
// valid/ready channel with in-order responses, and hands {pc, pc+4, instr} to
// decode. Redirects reload the PC, flush the output queue and arrange for the
// responses of fetches already in flight to be discarded.
//
// A two-entry credit pool is shared between outstanding fetches and queued
// instructions. A request issues only while inflight + queued < 2, so neither
// the tag FIFO nor the output FIFO can overflow, and imem never has to hold a
// response back.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr
);

    logic [31:0] pc_q;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  drop_q, drop_d;
    logic        misalign_q;

    // Tag FIFO: PC of each outstanding request. Occupancy equals inflight_q.
    logic [31:0] tag_q [2];
    logic        tag_wr_q, tag_rd_q;

    // Output FIFO of {pc, instr} waiting for decode.
    logic [31:0] opc_q [2];
    logic [31:0] oins_q [2];
    logic        out_wr_q, out_rd_q;
    logic [1:0]  out_cnt_q, out_cnt_d;

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic rsp_keep;
    logic out_pop;

    // Request issue, response retirement and next-state counters.
    always_comb begin
        credit_ok      = ({1'b0, inflight_q} + {1'b0, out_cnt_q}) < 3'd2;
        // rst_n gating keeps the request channel quiet while reset is held.
        imem_req_valid = rst_n && credit_ok && !redirect_valid;
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is ignored (flagged below).
        rsp_fire       = imem_rsp_valid && (inflight_q != 2'd0);
        // The response arriving in a redirect cycle is discarded as well.
        rsp_keep       = rsp_fire && !redirect_valid && (drop_q == 2'd0);
        out_pop        = (out_cnt_q != 2'd0) && if_ready && !redirect_valid;

        inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, rsp_fire};

        drop_d = drop_q;
        if (redirect_valid) begin
            // No request issues in a redirect cycle, so inflight_d is the
            // count left after this cycle's response; all of it is stale.
            drop_d = inflight_d;
        end else if (rsp_fire && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end

        out_cnt_d = out_cnt_q + {1'b0, rsp_keep} - {1'b0, out_pop};
        if (redirect_valid) begin
            out_cnt_d = 2'd0;
        end
    end

    // Decode-side view of the output FIFO head.
    always_comb begin
        if_valid = (out_cnt_q != 2'd0);
        if_pc    = opc_q[out_rd_q];
        if_instr = oins_q[out_rd_q];
        if_pc4   = if_pc + 32'd4;
        misalign = misalign_q;
    end

    // PC, counters, both FIFOs and the misalign pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            misalign_q <= 1'b0;
            tag_q[0]   <= 32'd0;
            tag_q[1]   <= 32'd0;
            tag_wr_q   <= 1'b0;
            tag_rd_q   <= 1'b0;
            opc_q[0]   <= 32'd0;
            opc_q[1]   <= 32'd0;
            oins_q[0]  <= 32'd0;
            oins_q[1]  <= 32'd0;
            out_wr_q   <= 1'b0;
            out_rd_q   <= 1'b0;
            out_cnt_q  <= 2'd0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            out_cnt_q  <= out_cnt_d;
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire) begin
                pc_q <= pc_q + 32'd4;
            end

            if (req_fire) begin
                tag_q[tag_wr_q] <= pc_q;
                tag_wr_q        <= ~tag_wr_q;
            end
            if (rsp_fire) begin
                tag_rd_q <= ~tag_rd_q;
            end

            if (redirect_valid) begin
                out_wr_q <= 1'b0;
                out_rd_q <= 1'b0;
            end else begin
                if (rsp_keep) begin
                    opc_q[out_wr_q]  <= tag_q[tag_rd_q];
                    oins_q[out_wr_q] <= imem_rsp_data;
                    out_wr_q         <= ~out_wr_q;
                end
                if (out_pop) begin
                    out_rd_q <= ~out_rd_q;
                end
            end
        end
    end

    // Protocol check: imem must not respond with nothing outstanding.
    rsp_without_request : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (inflight_q == 2'd0))
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit. The reference model works on whole
// fetches: each accepted request is remembered with the redirect epoch it was
// issued in, responses from an older epoch (or arriving with a redirect) are
// thrown away, surviving ones join an expected decode queue.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        int          ep;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] outq[$];
    int          epoch;
    logic [31:0] nxt_req;
    logic        mis_exp;
    int          delivered;

    int unsigned k_ready, k_rsp, k_ifr, k_redir;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        pend.delete();
        outq.delete();
        epoch++;
        nxt_req = RPC;
        mis_exp = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid",  {31'b0, if_valid},       32'd0);
        chk("rst_misalign",  {31'b0, misalign},       32'd0);
        chk("rst_req_addr",  imem_req_addr,           RPC);
        chk("rst_if_pc",     if_pc,                   32'd0);
        chk("rst_if_instr",  if_instr,                32'd0);
        chk("rst_if_pc4",    if_pc4,                  32'd4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        if_ready       = 1'b0;
        #1;
        check_reset_values();
        model_clear();
        @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance the model.
    task automatic cycle(input bit force_redir, input logic [31:0] fpc);
        logic  exp_rv;
        logic  keep;
        pend_t h;
        @(negedge clk);
        redirect_valid = force_redir || ($urandom_range(99) < k_redir);
        redirect_pc    = force_redir ? fpc : $urandom;
        imem_req_ready = ($urandom_range(99) < k_ready);
        if_ready       = ($urandom_range(99) < k_ifr);
        if (pend.size() > 0 && $urandom_range(99) < k_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ins_of(pend[0].pc);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = ((pend.size() + outq.size()) < 2) && !redirect_valid;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        chk("req_addr",  imem_req_addr, nxt_req);
        chk("if_valid",  {31'b0, if_valid}, {31'b0, outq.size() != 0});
        chk("misalign",  {31'b0, misalign}, {31'b0, mis_exp});
        if (outq.size() != 0) begin
            chk("if_pc",    if_pc,    outq[0]);
            chk("if_pc4",   if_pc4,   outq[0] + 32'd4);
            chk("if_instr", if_instr, ins_of(outq[0]));
        end

        keep = 1'b0;
        if (imem_rsp_valid) begin
            h    = pend.pop_front();
            keep = !redirect_valid && (h.ep == epoch);
        end
        if (outq.size() > 0 && if_ready && !redirect_valid) begin
            void'(outq.pop_front());
            delivered++;
        end
        if (keep) outq.push_back(h.pc);
        if (exp_rv && imem_req_ready) begin
            pend.push_back('{pc: nxt_req, ep: epoch});
            nxt_req = nxt_req + 32'd4;
        end
        mis_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            outq.delete();
            epoch++;
            nxt_req = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0);
    endtask

    task automatic knobs(input int unsigned r, input int unsigned s,
                         input int unsigned f, input int unsigned d);
        k_ready = r;
        k_rsp   = s;
        k_ifr   = f;
        k_redir = d;
    endtask

    int d0;

    initial begin
        epoch     = 0;
        delivered = 0;
        rst_n     = 1'b0;
        knobs(100, 100, 100, 0);
        do_reset();

        // Straight-line fetch from the reset PC.
        run(30);
        chk("liveness_straight", {31'b0, delivered > 10}, 32'd1);

        // Decode stall, then release.
        knobs(100, 100, 0, 0);
        run(5);
        knobs(100, 100, 100, 0);
        run(10);

        // Build up two outstanding fetches, then redirect to 0x400 while a
        // response lands and imem is not ready.
        knobs(100, 0, 100, 0);
        run(4);
        knobs(0, 100, 100, 0);
        cycle(1'b1, 32'h0000_0400);
        knobs(100, 100, 100, 0);
        run(15);

        // Back-to-back redirects, the second misaligned.
        cycle(1'b1, 32'h0000_0800);
        cycle(1'b1, 32'h0000_0306);
        run(10);

        // Wrap from the top of the address space.
        cycle(1'b1, 32'hFFFF_FFF4);
        run(14);

        // Randomized traffic.
        d0 = delivered;
        knobs(70, 60, 70, 5);
        run(400);
        chk("liveness_random", {31'b0, (delivered - d0) > 40}, 32'd1);

        // Reset in the middle of activity.
        do_reset();
        knobs(100, 100, 100, 0);
        d0 = delivered;
        run(20);
        chk("liveness_after_reset", {31'b0, (delivered - d0) > 5}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
